mux_select_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the 16-channel one-hot multiplexer and drives its 16-bit `select` bus. It accepts a 4-bit opcode over a valid/ready handshake and decodes it to a one-hot select. The select is held for an opcode-dependent number of cycles. A one-cycle `acc_load` strobe tells the downstream result register to capture the mux output, and a `done` pulse and completed-operation count follow.

---
 rtl/mux_select_sequencer_pkg.sv | 17 +
 rtl/mux_select_sequencer_if.sv | 29 ++
 rtl/mux_select_sequencer_decoder.sv | 19 +
 rtl/mux_select_sequencer.sv | 107 ++++++++++
 tb/tb_mux_select_sequencer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mux_select_sequencer_pkg.sv
// Shared definitions for the mux select sequencer: state encoding, channel
// geometry and the default long-operation mask.
package mux_seq_pkg;

    localparam int NUM_CHAN = 16;
    localparam int OP_W     = 4;
    localparam int DCNT_W   = 4;

    localparam logic [NUM_CHAN-1:0] DEFAULT_LONG_MASK = 16'hFF00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/mux_select_sequencer_if.sv
// Command/select bundle between a command producer and the sequencer.
// The master issues opcodes and aborts; the slave drives the mux select
// and the status outputs.
interface mux_select_sequencer_if #(
    parameter int CNT_W = 8
);
    import mux_seq_pkg::*;

    logic                cmd_valid;
    logic [OP_W-1:0]     cmd_op;
    logic                cmd_ready;
    logic                abort;
    logic [NUM_CHAN-1:0] select;
    logic                acc_load;
    logic                done;
    logic                busy;
    logic [CNT_W-1:0]    op_count;

    modport master (
        output cmd_valid, cmd_op, abort,
        input  cmd_ready, select, acc_load, done, busy, op_count
    );

    modport slave (
        input  cmd_valid, cmd_op, abort,
        output cmd_ready, select, acc_load, done, busy, op_count
    );

endinterface

// File: rtl/mux_select_sequencer_decoder.sv
// Index-to-one-hot decoder for mux select buses. Purely combinational so any
// select producer can reuse it; a low enable forces the output to all-zero.
module op_onehot_decoder
    import mux_seq_pkg::*;
(
    input  logic [OP_W-1:0]     index,
    input  logic                en,
    output logic [NUM_CHAN-1:0] onehot
);

    // At most one bit is ever set, and none when disabled.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[index] = 1'b1;
        end
    end

endmodule

// File: rtl/mux_select_sequencer.sv
// Command sequencer in front of the 16-channel one-hot mux. Accepts an opcode,
// holds the matching select for one or LONG_CYCLES cycles, strobes acc_load on
// the last drive cycle, then pulses done and bumps the completed-op counter.
module mux_select_sequencer
    import mux_seq_pkg::*;
#(
    parameter logic [NUM_CHAN-1:0] LONG_MASK   = DEFAULT_LONG_MASK,
    parameter int                  LONG_CYCLES = 4,
    parameter int                  CNT_W       = 8
)(
    input  logic                  clk,
    input  logic                  rst,
    mux_select_sequencer_if.slave bus
);

    localparam logic [DCNT_W-1:0] LONG_LOAD = DCNT_W'(LONG_CYCLES - 1);

    seq_state_t          state;
    seq_state_t          state_next;
    logic [OP_W-1:0]     op_q;
    logic [DCNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]    op_count_q;
    logic                accept;
    logic                drive_en;
    logic [NUM_CHAN-1:0] sel_dec;

    // cmd_ready is exactly "in IDLE", so a command is taken whenever one is
    // presented while idle.
    assign accept   = (state == IDLE) && bus.cmd_valid;
    assign drive_en = (state == DRIVE);

    // State register; reset drops straight back to IDLE so every decoded
    // output returns to its idle value without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: abort beats completion on the final drive cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (cnt_q == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Opcode latch and drive-length down-counter; the opcode is only sampled
    // on the accepting edge so the producer may change it afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            op_q  <= bus.cmd_op;
            cnt_q <= LONG_MASK[bus.cmd_op] ? LONG_LOAD : '0;
        end else if (drive_en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - DCNT_W'(1);
        end
    end

    // Completed-operation counter; aborted operations never reach DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_q <= '0;
        end else if (state == DONE) begin
            op_count_q <= op_count_q + CNT_W'(1);
        end
    end

    op_onehot_decoder u_decoder (
        .index  (op_q),
        .en     (drive_en),
        .onehot (sel_dec)
    );

    // Outputs decoded from state; acc_load alone also looks at abort so a
    // cancelled final cycle never triggers a capture downstream.
    always_comb begin
        bus.select    = sel_dec;
        bus.cmd_ready = (state == IDLE);
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
        bus.acc_load  = drive_en && (cnt_q == '0) && !bus.abort;
        bus.op_count  = op_count_q;
    end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench for mux_select_sequencer: short/long ops, aborts,
// back-to-back commands under backpressure, counter wrap and async reset.
module tb_mux_select_sequencer;

    localparam int CNT_W       = 8;
    localparam int LONG_CYCLES = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [CNT_W-1:0] exp_count;

    always #5 clk = ~clk;

    mux_select_sequencer_if #(.CNT_W(CNT_W)) bus ();

    mux_select_sequencer #(
        .LONG_MASK   (16'hFF00),
        .LONG_CYCLES (LONG_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] op, input logic ab);
        bus.cmd_valid = valid;
        bus.cmd_op    = op;
        bus.abort     = ab;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    // Issue one command from IDLE and check the whole timeline for n drive cycles.
    task automatic runOp(input logic [3:0] op, input int n, input logic [15:0] exp_sel);
        checkOutput("ready_before", 32'(bus.cmd_ready), 32'd1);
        applyStimulus(1'b1, op, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b0);
        for (int c = 1; c <= n; c++) begin
            checkOutput("drive_select", 32'(bus.select), 32'(exp_sel));
            checkOutput("drive_acc_load", 32'(bus.acc_load), 32'(c == n));
            checkOutput("drive_ready", 32'(bus.cmd_ready), 32'd0);
            checkOutput("drive_busy", 32'(bus.busy), 32'd1);
            if (c < n) nextCycle();
        end
        nextCycle();
        checkOutput("done_pulse", 32'(bus.done), 32'd1);
        checkOutput("done_select", 32'(bus.select), 32'd0);
        checkOutput("done_count_old", 32'(bus.op_count), 32'(exp_count));
        exp_count = exp_count + 1'b1;
        nextCycle();
        checkOutput("after_done", 32'(bus.done), 32'd0);
        checkOutput("after_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("after_count", 32'(bus.op_count), 32'(exp_count));
    endtask

    initial begin
        exp_count = '0;
        rst = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b0);
        repeat (2) nextCycle();

        // Reset values
        checkOutput("rst_select", 32'(bus.select), 32'd0);
        checkOutput("rst_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_acc_load", 32'(bus.acc_load), 32'd0);
        checkOutput("rst_count", 32'(bus.op_count), 32'd0);
        rst = 1'b0;
        nextCycle();

        // Short op 3, then long op 12
        runOp(4'd3, 1, 16'h0008);
        runOp(4'd12, LONG_CYCLES, 16'h1000);

        // Abort on the second drive cycle of long op 9
        applyStimulus(1'b1, 4'd9, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("ab1_sel_d1", 32'(bus.select), 32'h0200);
        checkOutput("ab1_acc_d1", 32'(bus.acc_load), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b1);
        #1;
        checkOutput("ab1_sel_d2", 32'(bus.select), 32'h0200);
        checkOutput("ab1_acc_d2", 32'(bus.acc_load), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("ab1_sel_clr", 32'(bus.select), 32'd0);
        checkOutput("ab1_busy", 32'(bus.busy), 32'd0);
        checkOutput("ab1_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("ab1_done", 32'(bus.done), 32'd0);
        nextCycle();
        checkOutput("ab1_done_late", 32'(bus.done), 32'd0);
        checkOutput("ab1_count", 32'(bus.op_count), 32'(exp_count));

        // Abort on the final drive cycle: acc_load must stay low
        applyStimulus(1'b1, 4'd9, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b0);
        repeat (LONG_CYCLES - 1) nextCycle();
        checkOutput("ab2_acc_pre", 32'(bus.acc_load), 32'd1);
        applyStimulus(1'b0, 4'd0, 1'b1);
        #1;
        checkOutput("ab2_acc_final", 32'(bus.acc_load), 32'd0);
        checkOutput("ab2_sel_final", 32'(bus.select), 32'h0200);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("ab2_sel_clr", 32'(bus.select), 32'd0);
        checkOutput("ab2_done", 32'(bus.done), 32'd0);
        checkOutput("ab2_ready", 32'(bus.cmd_ready), 32'd1);
        nextCycle();
        checkOutput("ab2_done_late", 32'(bus.done), 32'd0);
        checkOutput("ab2_count", 32'(bus.op_count), 32'(exp_count));

        // Abort while idle has no effect
        applyStimulus(1'b0, 4'd0, 1'b1);
        #1;
        checkOutput("idle_abort_acc", 32'(bus.acc_load), 32'd0);
        nextCycle();
        checkOutput("idle_abort_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("idle_abort_busy", 32'(bus.busy), 32'd0);
        applyStimulus(1'b0, 4'd0, 1'b0);

        // Backpressure: valid held across op 1 then op 2
        applyStimulus(1'b1, 4'd1, 1'b0);
        nextCycle();
        checkOutput("bp_sel1", 32'(bus.select), 32'h0002);
        checkOutput("bp_acc1", 32'(bus.acc_load), 32'd1);
        applyStimulus(1'b1, 4'd2, 1'b0);
        nextCycle();
        checkOutput("bp_done1", 32'(bus.done), 32'd1);
        checkOutput("bp_gap1", 32'(bus.select), 32'd0);
        checkOutput("bp_held_ready", 32'(bus.cmd_ready), 32'd0);
        nextCycle();
        checkOutput("bp_ready_back", 32'(bus.cmd_ready), 32'd1);
        checkOutput("bp_gap2", 32'(bus.select), 32'd0);
        checkOutput("bp_count1", 32'(bus.op_count), 32'(exp_count + 8'd1));
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("bp_sel2", 32'(bus.select), 32'h0004);
        checkOutput("bp_onehot", 32'($countones(bus.select)), 32'd1);
        nextCycle();
        checkOutput("bp_done2", 32'(bus.done), 32'd1);
        nextCycle();
        checkOutput("bp_count2", 32'(bus.op_count), 32'(exp_count + 8'd2));
        exp_count = exp_count + 8'd2;
        nextCycle();
        checkOutput("bp_no_reaccept", 32'(bus.busy), 32'd0);
        checkOutput("bp_idle_sel", 32'(bus.select), 32'd0);

        // Asynchronous reset in the middle of a long op
        applyStimulus(1'b1, 4'd15, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b0);
        nextCycle();
        checkOutput("mid_sel_before", 32'(bus.select), 32'h8000);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid_rst_sel", 32'(bus.select), 32'd0);
        checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("mid_rst_acc", 32'(bus.acc_load), 32'd0);
        checkOutput("mid_rst_count", 32'(bus.op_count), 32'd0);
        nextCycle();
        rst = 1'b0;
        exp_count = '0;
        nextCycle();
        checkOutput("mid_rst_no_done", 32'(bus.done), 32'd0);
        checkOutput("mid_rst_idle", 32'(bus.busy), 32'd0);

        // 256 short ops wrap the 8-bit counter back to zero
        for (int i = 0; i < 256; i++) begin
            logic [15:0] sel;
            sel = 16'h0001 << (i % 8);
            runOp(4'(i % 8), 1, sel);
        end
        checkOutput("wrap_zero", 32'(bus.op_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
